// File: rtl/uart_pkg.sv
// Shared constants, state encoding and timing helper for the UART transmit path.
package uart_pkg;

   localparam int   FRAME_BITS = 10;
   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2
   } tx_state_e;

   // Clock cycles per UART symbol; truncating division.
   function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Symbol timer: counts 0..N_CYCLES-1 while enabled and emits a tick on the wrap cycle.
module uart_baud_gen #(
   parameter int N_CYCLES = 1085
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int             CW   = (N_CYCLES > 1) ? $clog2(N_CYCLES) : 1;
   localparam logic [CW-1:0]  LAST = CW'(N_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      tick  = en && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_fifo_tx.sv
// 8N1 UART transmitter draining a registered-output byte FIFO, with CTS-style start gating
// and a wrapping count of completed frames.
module uart_fifo_tx
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic [7:0]           fifo_dout,
   input  logic                 tx_enable,
   output logic                 serial_out,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] frames_sent
);

   // state    | meaning
   // ST_IDLE  | line idle; pop when FIFO has data and tx_enable is set
   // ST_FETCH | FIFO dout valid this cycle; load frame, clear symbol timer
   // ST_SEND  | shifting the 10-bit frame out LSB first

   localparam int SYM_CYCLES = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);

   tx_state_e              state_q, state_d;
   logic [FRAME_BITS-1:0]  shift_q, shift_d;
   logic [3:0]             bit_idx_q, bit_idx_d;
   logic [CNT_WIDTH-1:0]   frames_q, frames_d;
   logic                   baud_tick;
   logic                   last_bit;

   uart_baud_gen #(
      .N_CYCLES (SYM_CYCLES)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_q == ST_FETCH),
      .en   (state_q == ST_SEND),
      .tick (baud_tick)
   );

   assign last_bit = (bit_idx_q == 4'(FRAME_BITS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '1;
         bit_idx_q <= '0;
         frames_q  <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         frames_q  <= frames_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (fifo_rd_en) state_d = ST_FETCH;
         ST_FETCH: state_d = ST_SEND;
         ST_SEND:  if (baud_tick && last_bit) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      frames_d  = frames_q;
      if (state_q == ST_FETCH) begin
         shift_d   = {IDLE_LEVEL, fifo_dout, 1'b0};
         bit_idx_d = '0;
      end else if (state_q == ST_SEND && baud_tick) begin
         shift_d   = {IDLE_LEVEL, shift_q[FRAME_BITS-1:1]};
         bit_idx_d = bit_idx_q + 4'd1;
         if (last_bit) begin
            frames_d = frames_q + 1'b1;
         end
      end
   end

   // The rst term keeps a pop from being lost while the FSM is held in reset.
   always_comb begin
      fifo_rd_en = (state_q == ST_IDLE) && !fifo_empty && tx_enable && !rst;
      serial_out = (state_q == ST_SEND) ? shift_q[0] : IDLE_LEVEL;
      busy       = (state_q != ST_IDLE);
   end

   assign frames_sent = frames_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx at 10 cycles/bit, with a registered-output FIFO model.
module tb_uart_fifo_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_enable = 1'b0;
   logic [7:0]  fifo_dout = 8'h00;
   logic        fifo_empty;
   logic        fifo_rd_en, serial_out, busy;
   logic [15:0] frames_sent;
   logic        rd_en2, serial2, busy2;
   logic [1:0]  frames2;

   logic [7:0]  mem [0:31];
   logic [4:0]  wr_ptr = '0;
   logic [4:0]  rd_ptr = '0;

   int checks = 0;
   int errors = 0;
   int rd_cnt = 0;
   int viol = 0;
   int cyc = 0;
   int exp_frames = 0;
   int last_pop = 0;

   always #5 clk = ~clk;

   uart_fifo_tx #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_dout(fifo_dout), .tx_enable(tx_enable), .serial_out(serial_out),
      .busy(busy), .frames_sent(frames_sent)
   );

   uart_fifo_tx #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .CNT_WIDTH(2)) dut_w2 (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en2),
      .fifo_dout(fifo_dout), .tx_enable(tx_enable), .serial_out(serial2),
      .busy(busy2), .frames_sent(frames2)
   );

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en) begin
         rd_cnt    <= rd_cnt + 1;
         fifo_dout <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 5'd1;
         if (fifo_empty || busy) viol <= viol + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 5'd1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_frames = 0;
   endtask

   function automatic logic fbit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[k-1];
   endfunction

   task automatic wait_pop(input int limit, output bit ok);
      ok = 1'b0;
      #1;
      for (int i = 0; i < limit; i++) begin
         if (fifo_rd_en) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
      chk("pop_timeout", 32'd0, 32'd1);
   endtask

   // Expects a pop to be pending; checks the whole 102-cycle pop-to-idle sequence.
   task automatic send_frame(input logic [7:0] b, input int drop_at, input bit check_gap);
      bit ok;
      int mism;
      int pop_cyc;
      wait_pop(300, ok);
      if (!ok) return;
      pop_cyc = cyc;
      if (check_gap) chk("pop_spacing", 32'(pop_cyc - last_pop), 32'd102);
      tick();
      chk("rd_en_single_pulse", {31'd0, fifo_rd_en}, 32'd0);
      chk("fetch_line_high", {31'd0, serial_out}, 32'd1);
      mism = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (serial_out !== fbit(b, k / 10)) mism++;
         if (busy !== 1'b1) mism++;
         if (k == drop_at) tx_enable = 1'b0;
      end
      chk("frame_bits", 32'(mism), 32'd0);
      tick();
      exp_frames++;
      chk("frames_after_frame", {16'd0, frames_sent}, 32'(exp_frames));
      chk("busy_after_frame", {31'd0, busy}, 32'd0);
      last_pop = pop_cyc;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int pops0;
      int bad;
      bit ok;
      logic [1:0] exp_w2 [0:4];
      logic [7:0] bytes6 [0:4];
      exp_w2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      bytes6 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};

      // 1: idle with empty FIFO
      tx_enable = 1'b1;
      do_reset();
      chk("reset_serial", {31'd0, serial_out}, 32'd1);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_frames", {16'd0, frames_sent}, 32'd0);
      pops0 = rd_cnt;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (serial_out !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
      end
      chk("idle_empty_quiet", 32'(bad), 32'd0);
      chk("idle_empty_no_pop", 32'(rd_cnt - pops0), 32'd0);
      chk("idle_empty_frames", {16'd0, frames_sent}, 32'd0);

      // 2: single byte
      pops0 = rd_cnt;
      push(8'hA5);
      send_frame(8'hA5, -1, 1'b0);
      chk("single_pop_count", 32'(rd_cnt - pops0), 32'd1);

      // 3: back-to-back frames
      do_reset();
      pops0 = rd_cnt;
      push(8'h00);
      push(8'hFF);
      push(8'h3C);
      send_frame(8'h00, -1, 1'b0);
      send_frame(8'hFF, -1, 1'b1);
      send_frame(8'h3C, -1, 1'b1);
      chk("b2b_frames", {16'd0, frames_sent}, 32'd3);
      chk("b2b_pop_count", 32'(rd_cnt - pops0), 32'd3);

      // 4: tx_enable gating
      do_reset();
      tx_enable = 1'b0;
      pops0 = rd_cnt;
      push(8'h96);
      push(8'h4B);
      for (int i = 0; i < 20; i++) tick();
      chk("gated_no_pop", 32'(rd_cnt - pops0), 32'd0);
      chk("gated_busy", {31'd0, busy}, 32'd0);
      tx_enable = 1'b1;
      send_frame(8'h96, 30, 1'b0);
      for (int i = 0; i < 30; i++) tick();
      chk("gated_one_pop", 32'(rd_cnt - pops0), 32'd1);
      chk("gated_queue_left", 32'(5'(wr_ptr - rd_ptr)), 32'd1);
      chk("gated_rd_en_low", {31'd0, fifo_rd_en}, 32'd0);
      chk("gated_frames", {16'd0, frames_sent}, 32'd1);

      // 5: reset mid-frame
      tx_enable = 1'b1;
      send_frame(8'h4B, -1, 1'b0);
      push(8'h55);
      push(8'h81);
      wait_pop(300, ok);
      for (int i = 0; i < 47; i++) tick();
      chk("midframe_was_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      chk("rst_mid_serial", {31'd0, serial_out}, 32'd1);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_frames", {16'd0, frames_sent}, 32'd0);
      chk("rst_mid_frames_w2", {30'd0, frames2}, 32'd0);
      chk("rst_mid_no_pop", {31'd0, fifo_rd_en}, 32'd0);
      rst = 1'b0;
      exp_frames = 0;
      send_frame(8'h81, -1, 1'b0);

      // 6: frame counter wrap on the 2-bit instance
      do_reset();
      for (int i = 0; i < 5; i++) push(bytes6[i]);
      for (int i = 0; i < 5; i++) begin
         send_frame(bytes6[i], -1, i > 0);
         chk("frames_w2_wrap", {30'd0, frames2}, {30'd0, exp_w2[i]});
      end

      chk("rd_en_protocol", 32'(viol), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
